// File: rtl/argmax_pkg.sv
// Shared types for argmax_stream: ranked candidate record, top-2 pair, merge rule and FSM states.
// Scores are sign-extended to CAND_W so one struct serves any DATA_W below CAND_W.
package argmax_pkg;
  localparam int CAND_W    = 64;
  localparam int IDX_MAX_W = 16;

  typedef struct packed {
    logic                     vld;
    logic signed [CAND_W-1:0] val;
    logic [IDX_MAX_W-1:0]     idx;
  } cand_t;

  typedef struct packed {
    cand_t first;
    cand_t second;
  } pair_t;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Higher value wins; equal values go to the lower class index. Invalid never wins.
  function automatic logic better(cand_t a, cand_t b);
    if (!a.vld) return 1'b0;
    if (!b.vld) return 1'b1;
    return (a.val > b.val) || ((a.val == b.val) && (a.idx < b.idx));
  endfunction

  function automatic pair_t merge(pair_t a, pair_t b);
    pair_t r;
    if (better(a.first, b.first)) begin
      r.first  = a.first;
      r.second = better(a.second, b.first) ? a.second : b.first;
    end else begin
      r.first  = b.first;
      r.second = better(a.first, b.second) ? a.first : b.second;
    end
    return r;
  endfunction
endpackage

// File: rtl/argmax_stream_if.sv
// Beat intake and result buffer signals of argmax_stream; slave is the argmax block.
interface argmax_stream_if #(
  parameter int DATA_W = 54,
  parameter int LANES  = 2,
  parameter int IDX_W  = 4
);
  logic                         in_valid;
  logic                         in_ready;
  logic [LANES-1:0][DATA_W-1:0] in_data;
  logic                         in_last;
  logic                         out_valid;
  logic                         out_ready;
  logic [IDX_W-1:0]             out_idx;
  logic signed [DATA_W-1:0]     out_val;
  logic [IDX_W-1:0]             out_idx2;
  logic [DATA_W:0]              out_margin;
  logic                         out_err;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_idx, out_val, out_idx2, out_margin, out_err
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_idx, out_val, out_idx2, out_margin, out_err
  );
endinterface

// File: rtl/argmax_lane_reduce.sv
// Combinational top-2 of one beat: a binary tree of merge stages over the masked lanes.
module argmax_lane_reduce
  import argmax_pkg::*;
#(
  parameter int LANES = 2
) (
  input  cand_t            cand [LANES],
  input  logic [LANES-1:0] mask,
  output pair_t            top
);
  localparam int LEAVES = 1 << $clog2(LANES);

  pair_t node [2*LEAVES-1];

  function automatic pair_t leaf(cand_t c, logic m);
    pair_t p;
    p.first     = c;
    p.first.vld = c.vld & m;
    p.second    = '0;
    return p;
  endfunction

  for (genvar i = 0; i < LEAVES; i++) begin : g_leaf
    if (i < LANES) begin : g_used
      assign node[LEAVES-1+i] = leaf(cand[i], mask[i]);
    end else begin : g_pad
      assign node[LEAVES-1+i] = '0;
    end
  end

  for (genvar i = 0; i < LEAVES-1; i++) begin : g_node
    assign node[i] = merge(node[2*i+1], node[2*i+2]);
  end

  assign top = node[0];
endmodule

// File: rtl/argmax_stream.sv
// Streaming argmax with running top-2; result registered one cycle after the closing beat.
// A closing beat stalls only while the one-entry result buffer is full and not draining.
module argmax_stream
  import argmax_pkg::*;
#(
  parameter int N_CLASSES = 10,
  parameter int DATA_W    = 54,
  parameter int LANES     = 2,
  parameter int IDX_W     = $clog2(N_CLASSES)
) (
  input logic            clk,
  input logic            rst,
  argmax_stream_if.slave bus
);
  localparam int BEATS = (N_CLASSES + LANES - 1) / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  logic [CNT_W-1:0]     cnt;
  state_t               state, state_nxt;
  cand_t                best, second;
  cand_t                cand [LANES];
  logic [LANES-1:0]     mask;
  logic [IDX_MAX_W-1:0] base;
  pair_t                beat_top, run, merged;
  logic                 at_end, closing, stall, accept, drain;
  logic [DATA_W-1:0]    top_v, sec_v;
  logic [DATA_W:0]      margin_c;

  assign base = IDX_MAX_W'(cnt) * IDX_MAX_W'(LANES);

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      cand[l].vld = 1'b1;
      cand[l].val = {{(CAND_W-DATA_W){bus.in_data[l][DATA_W-1]}}, bus.in_data[l]};
      cand[l].idx = base + IDX_MAX_W'(l);
      mask[l]     = cand[l].idx < IDX_MAX_W'(N_CLASSES);
    end
  end

  argmax_lane_reduce #(.LANES(LANES)) u_reduce (
    .cand (cand),
    .mask (mask),
    .top  (beat_top)
  );

  // The first beat of a frame must not see the previous frame's running pair.
  assign run    = '{first: best, second: second};
  assign merged = (cnt == '0) ? beat_top : merge(run, beat_top);

  // A single received class has no runner-up: report it against itself.
  assign top_v    = merged.first.val[DATA_W-1:0];
  assign sec_v    = merged.second.vld ? merged.second.val[DATA_W-1:0] : top_v;
  assign margin_c = {top_v[DATA_W-1], top_v} - {sec_v[DATA_W-1], sec_v};

  assign at_end  = (cnt == LAST_BEAT);
  assign closing = bus.in_last || at_end;
  assign drain   = bus.out_valid && bus.out_ready;

  always_comb begin
    state_nxt = state;
    stall     = bus.in_valid && closing && bus.out_valid && !bus.out_ready;
    unique case (state)
      ACCUM:   if (stall) state_nxt = HOLD;
      HOLD:    if (drain) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  assign bus.in_ready = !stall;
  assign accept       = bus.in_valid && !stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ACCUM;
      cnt            <= '0;
      best           <= '0;
      second         <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_idx    <= '0;
      bus.out_val    <= '0;
      bus.out_idx2   <= '0;
      bus.out_margin <= '0;
      bus.out_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        best   <= merged.first;
        second <= merged.second;
        cnt    <= closing ? '0 : cnt + 1'b1;
      end
      if (accept && closing) begin
        bus.out_valid  <= 1'b1;
        bus.out_idx    <= merged.first.idx[IDX_W-1:0];
        bus.out_val    <= top_v;
        bus.out_idx2   <= merged.second.vld ? merged.second.idx[IDX_W-1:0]
                                            : merged.first.idx[IDX_W-1:0];
        bus.out_margin <= margin_c;
        bus.out_err    <= bus.in_last != at_end;
      end else if (drain) begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_argmax_stream.sv
// Scoreboarded bench for argmax_stream: two instances (2 lanes, 3 lanes with padding).
module tb_argmax_stream;
  localparam int NC = 10;
  localparam int DW = 54;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  argmax_stream_if #(.DATA_W(DW), .LANES(2), .IDX_W(IW)) if_a ();
  argmax_stream_if #(.DATA_W(DW), .LANES(3), .IDX_W(IW)) if_b ();

  argmax_stream #(.N_CLASSES(NC), .DATA_W(DW), .LANES(2), .IDX_W(IW)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a));
  argmax_stream #(.N_CLASSES(NC), .DATA_W(DW), .LANES(3), .IDX_W(IW)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b));

  typedef struct {
    int     idx;
    longint val;
    int     idx2;
    longint margin;
    bit     err;
  } res_t;
  typedef longint frame_t [NC];

  res_t exp_a[$];
  res_t exp_b[$];
  int   checks   = 0;
  int   failures = 0;
  bit   rand_rdy_a = 1'b0;
  bit   rand_rdy_b = 1'b0;

  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: scan the received classes; strict '>' in ascending order keeps the lowest index on ties.
  function automatic res_t model(int lanes, frame_t sc, int nbeats, bit lastflag);
    int   nrecv;
    int   b;
    int   s;
    res_t r;
    nrecv = nbeats * lanes;
    if (nrecv > NC) nrecv = NC;
    b = 0;
    s = -1;
    for (int i = 1; i < nrecv; i++) if (sc[i] > sc[b]) b = i;
    for (int i = 0; i < nrecv; i++) if (i != b && (s < 0 || sc[i] > sc[s])) s = i;
    if (s < 0) s = b;
    r.idx    = b;
    r.val    = sc[b];
    r.idx2   = s;
    r.margin = sc[b] - sc[s];
    r.err    = lastflag != (nbeats == (NC + lanes - 1) / lanes);
    return r;
  endfunction

  task automatic compare(string tag, res_t e, int idx, longint val, int idx2, longint marg, bit err);
    check({tag, "_idx"}, idx, e.idx);
    check({tag, "_val"}, val, e.val);
    check({tag, "_idx2"}, idx2, e.idx2);
    check({tag, "_margin"}, marg, e.margin);
    check({tag, "_err"}, err, e.err);
  endtask

  always @(negedge clk) begin
    if (!rst && if_a.out_valid && if_a.out_ready) begin
      if (exp_a.size() == 0) begin
        checks++; failures++;
        $display("FAIL a_unexpected_result actual=idx%0d expected=none", if_a.out_idx);
      end else begin
        compare("a", exp_a.pop_front(), int'(if_a.out_idx), longint'(if_a.out_val),
                int'(if_a.out_idx2), longint'(if_a.out_margin), if_a.out_err);
      end
    end
    if (!rst && if_b.out_valid && if_b.out_ready) begin
      if (exp_b.size() == 0) begin
        checks++; failures++;
        $display("FAIL b_unexpected_result actual=idx%0d expected=none", if_b.out_idx);
      end else begin
        compare("b", exp_b.pop_front(), int'(if_b.out_idx), longint'(if_b.out_val),
                int'(if_b.out_idx2), longint'(if_b.out_margin), if_b.out_err);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_rdy_a) if_a.out_ready = ($urandom_range(0, 3) != 0);
    if (rand_rdy_b) if_b.out_ready = ($urandom_range(0, 2) != 0);
  end

  // Padding lanes carry a score above any real one so a leak would win.
  task automatic beat_vals(int w, frame_t sc, int b, output longint v[3]);
    int lanes;
    int c;
    lanes = (w == 0) ? 2 : 3;
    for (int l = 0; l < 3; l++) begin
      c = b * lanes + l;
      v[l] = (l < lanes && c < NC) ? sc[c] : 64'sd1000;
    end
  endtask

  task automatic present(int w, longint v[3], bit last);
    if (w == 0) begin
      if_a.in_valid = 1'b1;
      if_a.in_last  = last;
      for (int l = 0; l < 2; l++) if_a.in_data[l] = v[l][DW-1:0];
    end else begin
      if_b.in_valid = 1'b1;
      if_b.in_last  = last;
      for (int l = 0; l < 3; l++) if_b.in_data[l] = v[l][DW-1:0];
    end
  endtask

  task automatic drive(int w, longint v[3], bit last);
    int waited;
    waited = 0;
    present(w, v, last);
    forever begin
      @(negedge clk);
      if ((w == 0) ? if_a.in_ready : if_b.in_ready) break;
      waited++;
      if (waited > 100) begin
        checks++; failures++;
        $display("FAIL accept_timeout dut=%0d actual=stalled expected=accepted", w);
        break;
      end
    end
    @(posedge clk);
    #1;
    if (w == 0) if_a.in_valid = 1'b0;
    else        if_b.in_valid = 1'b0;
  endtask

  task automatic send_frame(int w, frame_t sc, int nbeats, bit lastflag, bit push, bit gaps);
    longint v[3];
    if (push) begin
      if (w == 0) exp_a.push_back(model(2, sc, nbeats, lastflag));
      else        exp_b.push_back(model(3, sc, nbeats, lastflag));
    end
    for (int b = 0; b < nbeats; b++) begin
      beat_vals(w, sc, b, v);
      drive(w, v, lastflag && (b == nbeats - 1));
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_drain(int w);
    int n;
    n = 0;
    while (((w == 0) ? exp_a.size() : exp_b.size()) != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    #1;
    check($sformatf("drain_pending_dut%0d", w), (w == 0) ? exp_a.size() : exp_b.size(), 0);
  endtask

  task automatic check_reset(string tag);
    check({tag, "_a_in_ready"}, if_a.in_ready, 1);
    check({tag, "_a_out_valid"}, if_a.out_valid, 0);
    check({tag, "_a_out_idx"}, if_a.out_idx, 0);
    check({tag, "_a_out_val"}, if_a.out_val, 0);
    check({tag, "_a_out_idx2"}, if_a.out_idx2, 0);
    check({tag, "_a_out_margin"}, if_a.out_margin, 0);
    check({tag, "_a_out_err"}, if_a.out_err, 0);
    check({tag, "_b_out_valid"}, if_b.out_valid, 0);
  endtask

  function automatic frame_t rnd_frame();
    frame_t f;
    int     mode;
    longint x;
    mode = $urandom_range(0, 2);
    for (int i = 0; i < NC; i++) begin
      x = longint'({$urandom(), $urandom()});
      x = (x <<< 10) >>> 10;
      if (mode == 1) x = longint'($urandom_range(0, 6)) - 3;
      if (mode == 2) x = ($urandom_range(0, 1) != 0)
                         ? -(longint'(1) <<< 53) + longint'($urandom_range(0, 2))
                         : (longint'(1) <<< 53) - 1 - longint'($urandom_range(0, 2));
      f[i] = x;
    end
    return f;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    frame_t sc;
    frame_t sc2;
    longint v[3];
    longint m;

    if_a.in_valid = 1'b0; if_a.in_last = 1'b0; if_a.in_data = '0; if_a.out_ready = 1'b0;
    if_b.in_valid = 1'b0; if_b.in_last = 1'b0; if_b.in_data = '0; if_b.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;

    // Reference frame, ties on 12 at classes 2 and 4.
    if_a.out_ready = 1'b1;
    sc = '{3, -7, 12, 0, 12, 5, -1, 9, 2, 11};
    exp_a.push_back(model(2, sc, 5, 1'b1));
    for (int b = 0; b < 4; b++) begin
      beat_vals(0, sc, b, v);
      drive(0, v, 1'b0);
    end
    beat_vals(0, sc, 4, v);
    check("t1_valid_before_close", if_a.out_valid, 0);
    drive(0, v, 1'b1);
    check("t1_valid_next_cycle", if_a.out_valid, 1);
    check("t1_idx", if_a.out_idx, 2);
    check("t1_idx2", if_a.out_idx2, 4);
    check("t1_val", if_a.out_val, 12);
    check("t1_margin", if_a.out_margin, 0);
    check("t1_err", if_a.out_err, 0);
    wait_drain(0);

    // Three lanes: final beat has two padding lanes at 1000.
    if_b.out_ready = 1'b1;
    for (int i = 0; i < NC; i++) sc[i] = longint'($urandom_range(0, 100)) - 50;
    send_frame(1, sc, 4, 1'b1, 1'b1, 1'b0);
    check("t2_idx_not_padding", (if_b.out_idx < NC) ? 1 : 0, 1);
    check("t2_err", if_b.out_err, 0);
    wait_drain(1);

    // Most negative scores, margin of one.
    m = -(longint'(1) <<< 53);
    for (int i = 0; i < NC; i++) sc[i] = m;
    sc[9] = m + 1;
    send_frame(0, sc, 5, 1'b1, 1'b1, 1'b0);
    check("t3_idx", if_a.out_idx, 9);
    check("t3_idx2", if_a.out_idx2, 0);
    check("t3_margin", if_a.out_margin, 1);
    wait_drain(0);

    // Held result: next frame intake continues until its closing beat.
    if_a.out_ready = 1'b0;
    sc = rnd_frame();
    send_frame(0, sc, 5, 1'b1, 1'b1, 1'b0);
    sc2 = rnd_frame();
    exp_a.push_back(model(2, sc2, 5, 1'b1));
    for (int b = 0; b < 4; b++) begin
      beat_vals(0, sc2, b, v);
      drive(0, v, 1'b0);
    end
    beat_vals(0, sc2, 4, v);
    present(0, v, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check("t4_stall_in_ready", if_a.in_ready, 0);
      check("t4_held_valid", if_a.out_valid, 1);
    end
    @(posedge clk);
    #1;
    if_a.out_ready = 1'b1;
    @(negedge clk);
    check("t4_release_in_ready", if_a.in_ready, 1);
    @(posedge clk);
    #1;
    if_a.in_valid = 1'b0;
    check("t4_no_bubble", if_a.out_valid, 1);
    wait_drain(0);

    // Early in_last on beat 2 of 5, then a clean frame.
    sc = rnd_frame();
    send_frame(0, sc, 3, 1'b1, 1'b1, 1'b0);
    check("t5_short_err", if_a.out_err, 1);
    sc = rnd_frame();
    send_frame(0, sc, 5, 1'b1, 1'b1, 1'b0);
    check("t5_clean_err", if_a.out_err, 0);
    wait_drain(0);

    // Reset with a held result and a partial frame in flight.
    if_a.out_ready = 1'b0;
    sc = rnd_frame();
    send_frame(0, sc, 5, 1'b1, 1'b0, 1'b0);
    sc = rnd_frame();
    send_frame(0, sc, 4, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset("t6_reset");
    rst = 1'b0;
    if_a.out_ready = 1'b1;
    sc = rnd_frame();
    send_frame(0, sc, 5, 1'b1, 1'b1, 1'b0);
    wait_drain(0);

    // Randomised frames on both instances with random output backpressure.
    rand_rdy_a = 1'b1;
    rand_rdy_b = 1'b1;
    fork
      begin
        frame_t fa;
        int     nb;
        bit     lf;
        for (int k = 0; k < 40; k++) begin
          fa = rnd_frame();
          nb = $urandom_range(1, 5);
          lf = (nb < 5) ? 1'b1 : bit'($urandom_range(0, 1));
          send_frame(0, fa, nb, lf, 1'b1, 1'b1);
        end
      end
      begin
        frame_t fb;
        int     nb;
        bit     lf;
        for (int k = 0; k < 25; k++) begin
          fb = rnd_frame();
          nb = $urandom_range(1, 4);
          lf = (nb < 4) ? 1'b1 : bit'($urandom_range(0, 1));
          send_frame(1, fb, nb, lf, 1'b1, 1'b1);
        end
      end
    join
    wait_drain(0);
    wait_drain(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/argmax_stream.md
# argmax_stream

Parametrised, streaming argmax for the classifier tail. It accepts class scores from the FC layer as LANES scores per beat over a valid/ready handshake and keeps a running top-2 as the beats arrive. At frame end it presents the winning class index, its score, the runner-up index and the top-1/top-2 margin through a one-entry output buffer. It replaces the fixed 10-input argmax and sits between the FC output stage and the result/UART reporting logic.

## Interface
Parameters:
- N_CLASSES, 10: number of class scores per frame; must be ≥ 2.
- DATA_W, 54: signed score width.
- LANES, 2: scores per input beat; must be ≥ 1.
- IDX_W, $clog2(N_CLASSES): class index width (derived).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset. Synchronous, active-high, single clock domain.
- in_valid  in  1  beat valid.
- in_ready  out  1  block accepts the beat.
- in_data  in  LANES×DATA_W signed  scores. Lane l of beat b is class b·LANES+l.
- in_last  in  1  producer marks the final beat of the frame.
- out_valid  out  1  result held.
- out_ready  in  1  consumer takes the result.
- out_idx  out  IDX_W  top-1 class.
- out_val  out  DATA_W signed  top-1 score.
- out_idx2  out  IDX_W  top-2 class.
- out_margin  out  DATA_W+1 unsigned  out_val minus the top-2 score, computed at full precision (never negative).
- out_err  out  1  frame-length mismatch on this result.

## Operation
- A beat is accepted on a cycle where in_valid and in_ready are both high. A beat counter runs from 0 to BEATS−1, where BEATS = ceil(N_CLASSES/LANES).
- Lanes whose class index is ≥ N_CLASSES (the padding on the final beat) are ignored. They never win and never count as runner-up.
- Per beat, a combinational reduce finds the beat's top-2. That result is merged with the running top-2 registers (best_val/idx, second_val/idx).
  - The first beat of a frame loads the running registers directly.
- Tie rule: on equal scores the lower class index ranks higher, everywhere. Because the class index is part of the comparison, it stays deterministic across beats.
- Frame close happens on an accepted beat where in_last=1 or the counter equals BEATS−1, whichever comes first.
  - The merged top-2 is written to the output buffer and the counter returns to 0.
  - out_err=1 when in_last and counter==BEATS−1 disagree.
  - A short frame (in_last early) reports the top-2 over the classes received. If only one class was received, the runner-up equals the top-1 and margin=0.
- FSM states:
  - ACCUM: normal beat intake.
  - HOLD: the result buffer is full and the next frame's final beat is pending.
  - Transitions:
    - ACCUM→HOLD when a closing beat is presented while out_valid=1 and out_ready=0.
    - HOLD→ACCUM on the first cycle the buffer drains.
- in_ready is low only when the presented beat would close a frame while the buffer is full and not draining in the same cycle. Non-closing beats of the next frame are always accepted during a held result.
- The output buffer drains on out_valid&&out_ready. A drain and a refill in the same cycle are allowed (back-to-back frames, no bubble).

## Timing
- Reset values:
  - Outputs: in_ready=1, out_valid=0, out_idx=0, out_val=0, out_idx2=0, out_margin=0, out_err=0.
  - Internals: counter=0, FSM=ACCUM, running registers cleared.
- Latency: closing beat accepted at cycle t gives out_valid=1 at t+1.
- Throughput: one beat per cycle sustained; a frame of BEATS beats gives one result every BEATS cycles.
- Outputs are stable while out_valid=1 and out_ready=0.
- Reset mid-frame discards partial state and any held result. The next accepted beat is class 0.
- Arithmetic: all compares are signed, DATA_W bits. The margin is sign-extended to DATA_W+1 before subtraction.

## Structure
- argmax_pkg holds:
  - the cand_t struct (signed val, idx);
  - the function better(a,b), which implements the value-then-lower-index rule;
  - the FSM state enum.
- Sub-module argmax_lane_reduce is combinational. It takes LANES candidates plus a valid mask and returns the beat's top-2. It is built as a generate tree of better() stages.
- The top level owns the counter, FSM, running merge, output buffer and handshakes.

## Test plan
- N_CLASSES=10, LANES=2, scores {3,−7,12,0,12,5,−1,9,2,11}, in_last on beat 4 → out_idx=2, out_idx2=4, out_val=12, out_margin=0, out_err=0, out_valid one cycle after the last beat.
- LANES=3, N_CLASSES=10 (4 beats, 2 padding lanes carrying 1000) → padding ignored; the true maximum among classes 0–9 is reported, out_err=0.
- All scores −2^53 except class 9 = −2^53+1 → out_idx=9, out_margin=1, with no overflow.
- Hold out_ready=0 while streaming a second frame → beats 0–3 are accepted; the closing beat stalls with in_ready=0. Raise out_ready → the first result drains, the second loads the same cycle, and out_valid stays high.
- in_last asserted on beat 2 of 5 → the result covers classes 0–5 with out_err=1. The next frame starts at class 0 and closes cleanly with out_err=0.
- Assert rst after beat 3 of a frame → all outputs return to reset values. A following full frame gives the correct result.
